// File: rtl/att_pkg.sv
// Shared types and widths for the address translation table writer.
// ATT_WRITER_VERIFY_EN adds the read-back verify states.
package att_pkg;

    localparam int ATT_AW    = 12;
    localparam int ATT_CTW   = 11;
    localparam int ATT_MW    = 20;
    localparam int ATT_DEPTH = 4096;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE
`ifdef ATT_WRITER_VERIFY_EN
        ,
        VRD,
        VCMP
`endif
    } att_wr_state_t;

    typedef struct packed {
        logic [ATT_AW-1:0]  index;
        logic [ATT_CTW-1:0] ct_addr;
        logic [ATT_MW-1:0]  mask;
    } att_entry_t;

endpackage

// File: rtl/att_table_writer_if.sv
// Host entry handshake plus table read/write port.
// slave = writer side, master = host/table side.
interface att_table_writer_if
    import att_pkg::*;
#(
    parameter int AW  = ATT_AW,
    parameter int CTW = ATT_CTW,
    parameter int MW  = ATT_MW
);
    logic           entry_valid;
    logic           entry_ready;
    logic [AW-1:0]  entry_index;
    logic [CTW-1:0] entry_ct_addr;
    logic [MW-1:0]  entry_mask;

    logic           write;
    logic           read;
    logic [AW-1:0]  address;
    logic [CTW-1:0] CT_address_in;
    logic [MW-1:0]  Mask_in;
    logic [CTW-1:0] CT_address;
    logic [MW-1:0]  Mask;

    modport slave (
        input  entry_valid, entry_index, entry_ct_addr, entry_mask,
        input  CT_address, Mask,
        output entry_ready, write, read, address,
        output CT_address_in, Mask_in
    );

    modport master (
        output entry_valid, entry_index, entry_ct_addr, entry_mask,
        output CT_address, Mask,
        input  entry_ready, write, read, address,
        input  CT_address_in, Mask_in
    );
endinterface

// File: rtl/att_table_writer_verify_chk.sv
// Read-back compare with sticky error and saturating mismatch count.
// Only instantiated when ATT_WRITER_VERIFY_EN is defined.
module att_verify_chk
    import att_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmp_en,
    input  logic [ATT_CTW-1:0] exp_ct,
    input  logic [ATT_MW-1:0]  exp_mask,
    input  logic [ATT_CTW-1:0] rd_ct,
    input  logic [ATT_MW-1:0]  rd_mask,
    output logic               err,
    output logic [7:0]         err_cnt
);
    logic mismatch;

    assign mismatch = (rd_ct != exp_ct) || (rd_mask != exp_mask);

    // Flag and count mismatches; count holds at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else if (cmp_en && mismatch) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: rtl/att_table_writer.sv
// Table programming engine: clear sweep after reset, then host writes.
// ATT_WRITER_VERIFY_EN adds read-back verify (VRD/VCMP) and err/err_cnt.
module att_table_writer
    import att_pkg::*;
#(
    parameter int DEPTH = ATT_DEPTH,
    parameter int AW    = ATT_AW,
    parameter int CTW   = ATT_CTW,
    parameter int MW    = ATT_MW
)(
    input  logic                clk,
    input  logic                rst,
    att_table_writer_if.slave   bus,
    output logic                init_done,
    output logic                busy,
    output logic                err,
    output logic [7:0]          err_cnt
);
    att_wr_state_t state;
    logic [AW-1:0] cnt;

`ifdef ATT_WRITER_VERIFY_EN
    att_entry_t ent;

    att_verify_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .cmp_en   (state == VCMP),
        .exp_ct   (ent.ct_addr),
        .exp_mask (ent.mask),
        .rd_ct    (bus.CT_address),
        .rd_mask  (bus.Mask),
        .err      (err),
        .err_cnt  (err_cnt)
    );
`else
    logic unused_rd;

    assign unused_rd = ^{bus.CT_address, bus.Mask};
    assign bus.read  = 1'b0;
    assign err       = 1'b0;
    assign err_cnt   = 8'd0;
`endif

    // Main FSM; every table and handshake output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= INIT;
            cnt               <= '0;
            bus.write         <= 1'b0;
            bus.address       <= '0;
            bus.CT_address_in <= '0;
            bus.Mask_in       <= '0;
            bus.entry_ready   <= 1'b0;
            init_done         <= 1'b0;
            busy              <= 1'b0;
`ifdef ATT_WRITER_VERIFY_EN
            bus.read          <= 1'b0;
            ent               <= '0;
`endif
        end else begin
            unique case (state)
                INIT: begin
                    if (bus.write && bus.address == AW'(DEPTH - 1)) begin
                        state           <= IDLE;
                        bus.write       <= 1'b0;
                        bus.entry_ready <= 1'b1;
                        init_done       <= 1'b1;
                        busy            <= 1'b0;
                    end else begin
                        bus.write         <= 1'b1;
                        bus.address       <= cnt;
                        bus.CT_address_in <= '0;
                        bus.Mask_in       <= '0;
                        cnt               <= cnt + 1'b1;
                        busy              <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.entry_valid && bus.entry_ready) begin
                        state             <= WRITE;
                        bus.write         <= 1'b1;
                        bus.address       <= bus.entry_index;
                        bus.CT_address_in <= bus.entry_ct_addr;
                        bus.Mask_in       <= bus.entry_mask;
                        bus.entry_ready   <= 1'b0;
                        busy              <= 1'b1;
`ifdef ATT_WRITER_VERIFY_EN
                        ent <= '{index:   bus.entry_index,
                                 ct_addr: bus.entry_ct_addr,
                                 mask:    bus.entry_mask};
`endif
                    end
                end
                WRITE: begin
                    bus.write <= 1'b0;
`ifdef ATT_WRITER_VERIFY_EN
                    state       <= VRD;
                    bus.read    <= 1'b1;
                    bus.address <= ent.index;
`else
                    state           <= IDLE;
                    bus.entry_ready <= 1'b1;
                    busy            <= 1'b0;
`endif
                end
`ifdef ATT_WRITER_VERIFY_EN
                VRD: begin
                    state    <= VCMP;
                    bus.read <= 1'b0;
                end
                VCMP: begin
                    state           <= IDLE;
                    bus.entry_ready <= 1'b1;
                    busy            <= 1'b0;
                end
`endif
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_att_table_writer.sv
// Scoreboard bench for att_table_writer (default and verify builds).
// Includes a simple registered-read table model.
module tb_att_table_writer;
    import att_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_done;
    logic       busy;
    logic       err;
    logic [7:0] err_cnt;

    att_table_writer_if bus ();

    att_table_writer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done),
        .busy      (busy),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    bit sb_on    = 1'b0;
    bit corrupt  = 1'b0;

    att_entry_t sb_q[$];

    logic [ATT_CTW+ATT_MW-1:0] mem [ATT_DEPTH];

`ifdef ATT_WRITER_VERIFY_EN
    localparam int GAP = 4;
`else
    localparam int GAP = 2;
`endif

    // Table model: registered read, optional mask bit 0 corruption.
    always @(posedge clk) begin
        logic [ATT_CTW+ATT_MW-1:0] flip;
        flip = corrupt ? 1 : 0;
        if (bus.write)
            mem[bus.address] <= {bus.CT_address_in, bus.Mask_in};
        if (bus.read)
            {bus.CT_address, bus.Mask} <= mem[bus.address] ^ flip;
    end

    // Scoreboard monitor: every host write must match the queue head.
    always @(negedge clk) begin
        if (sb_on) begin
            att_entry_t e;
            att_entry_t got;
            checks++;
            if (bus.write && bus.read) begin
                failures++;
                $display("FAIL wr_rd_overlap write=%0b read=%0b required not both",
                         bus.write, bus.read);
            end
`ifndef ATT_WRITER_VERIFY_EN
            checks++;
            if (bus.read !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
                failures++;
                $display("FAIL verify_off_ties read=%0b err=%0b cnt=%0d required 0",
                         bus.read, err, err_cnt);
            end
`endif
            if (bus.write) begin
                wr_seen++;
                checks++;
                got = '{index: bus.address, ct_addr: bus.CT_address_in,
                        mask: bus.Mask_in};
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got=%h required no write", got);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL sb_write got=%h required %h", got, e);
                    end
                end
            end
        end
    end

    task automatic drive_entry(input att_entry_t e);
        bus.entry_index   = e.index;
        bus.entry_ct_addr = e.ct_addr;
        bus.entry_mask    = e.mask;
    endtask

    task automatic run_sweep(output int n, output int bad, output bit tmo);
        n   = 0;
        bad = 0;
        tmo = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.write) begin
                tmo = 1'b0;
                break;
            end
        end
        if (tmo) return;
        for (int i = 0; i < ATT_DEPTH + 10 && bus.write; i++) begin
            if (bus.address !== ATT_AW'(n) || bus.CT_address_in !== '0 ||
                bus.Mask_in !== '0 || bus.entry_ready !== 1'b0)
                bad++;
            n++;
            @(negedge clk);
        end
        if (bus.write) tmo = 1'b1;
    endtask

    task automatic wait_ready(output bit tmo);
        tmo = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.entry_ready) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        int bad;
        bit tmo;
        rst = 1'b0;
        bus.entry_valid = 1'b0;
        drive_entry('0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.write !== 1'b0 || bus.address !== '0 ||
            bus.CT_address_in !== '0 || bus.Mask_in !== '0) begin
            failures++;
            $display("FAIL rst_table write=%0b addr=%h required 0", bus.write, bus.address);
        end
        checks++;
        if (bus.entry_ready !== 1'b0 || init_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_status rdy=%0b done=%0b busy=%0b required 0",
                     bus.entry_ready, init_done, busy);
        end
        checks++;
        if (bus.read !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_verify read=%0b err=%0b cnt=%0d required 0",
                     bus.read, err, err_cnt);
        end
        rst = 1'b1;
        run_sweep(n, bad, tmo);
        checks++;
        if (tmo || n !== ATT_DEPTH || bad !== 0) begin
            failures++;
            $display("FAIL sweep n=%0d bad=%0d tmo=%0b required n=4096 bad=0",
                     n, bad, tmo);
        end
        checks++;
        if (init_done !== 1'b1 || bus.entry_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sweep_end done=%0b rdy=%0b busy=%0b required 1 1 0",
                     init_done, bus.entry_ready, busy);
        end
    endtask

    task automatic test_single;
        att_entry_t e;
        e = '{index: 12'h123, ct_addr: 11'h5A5, mask: 20'hABCDE};
        sb_on = 1'b1;
        checks++;
        if (bus.entry_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_rdy got=%0b required 1", bus.entry_ready);
        end
        drive_entry(e);
        bus.entry_valid = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.entry_valid = 1'b0;
        checks++;
        if (bus.write !== 1'b1 || bus.address !== e.index ||
            bus.CT_address_in !== e.ct_addr || bus.Mask_in !== e.mask) begin
            failures++;
            $display("FAIL single_t1 wr=%0b a=%h ct=%h m=%h required 1 %h %h %h",
                     bus.write, bus.address, bus.CT_address_in, bus.Mask_in,
                     e.index, e.ct_addr, e.mask);
        end
        @(negedge clk);
`ifdef ATT_WRITER_VERIFY_EN
        checks++;
        if (bus.read !== 1'b1 || bus.write !== 1'b0 || bus.address !== e.index) begin
            failures++;
            $display("FAIL single_vrd rd=%0b wr=%0b a=%h required 1 0 %h",
                     bus.read, bus.write, bus.address, e.index);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.entry_ready !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_t4 rdy=%0b err=%0b required 1 0",
                     bus.entry_ready, err);
        end
`else
        checks++;
        if (bus.entry_ready !== 1'b1 || bus.write !== 1'b0) begin
            failures++;
            $display("FAIL single_t2 rdy=%0b wr=%0b required 1 0",
                     bus.entry_ready, bus.write);
        end
`endif
    endtask

    task automatic test_back_to_back;
        att_entry_t e;
        int n_ent = 10;
        int k = 0;
        int cyc = 0;
        int last = -1;
        int bad_gap = 0;
        int base;
        bit pend = 1'b0;
        base = wr_seen;
        e = '{index: ATT_AW'(12'h7F0), ct_addr: ATT_CTW'($urandom),
              mask: ATT_MW'($urandom)};
        drive_entry(e);
        bus.entry_valid = 1'b1;
        while (k < n_ent && cyc < 200) begin
            if (pend) begin
                pend = 1'b0;
                if (k < n_ent) begin
                    e = '{index: ATT_AW'(12'h7F0 + (k % 4)),
                          ct_addr: ATT_CTW'($urandom), mask: ATT_MW'($urandom)};
                    drive_entry(e);
                end
            end
            if (bus.entry_ready && bus.entry_valid) begin
                sb_q.push_back(e);
                if (last >= 0 && cyc - last != GAP) bad_gap++;
                last = cyc;
                k++;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.entry_valid = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (GAP) @(negedge clk);
        checks++;
        if (k !== n_ent || bad_gap !== 0) begin
            failures++;
            $display("FAIL b2b_accept n=%0d badgap=%0d required %0d 0", k, bad_gap, n_ent);
        end
        checks++;
        if (sb_q.size() !== 0 || wr_seen - base !== n_ent) begin
            failures++;
            $display("FAIL b2b_writes left=%0d seen=%0d required 0 %0d",
                     sb_q.size(), wr_seen - base, n_ent);
        end
`ifdef ATT_WRITER_VERIFY_EN
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL b2b_noerr err=%0b cnt=%0d required 0 0", err, err_cnt);
        end
`endif
    endtask

`ifdef ATT_WRITER_VERIFY_EN
    task automatic send_one(input att_entry_t e, output bit tmo);
        wait_ready(tmo);
        if (tmo) return;
        drive_entry(e);
        bus.entry_valid = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.entry_valid = 1'b0;
        wait_ready(tmo);
    endtask

    task automatic test_verify_err;
        att_entry_t e;
        bit tmo;
        int tmo_cnt = 0;
        corrupt = 1'b1;
        e = '{index: 12'h055, ct_addr: 11'h3C3, mask: 20'h12345};
        send_one(e, tmo);
        checks++;
        if (tmo || err !== 1'b1 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL verr_first err=%0b cnt=%0d tmo=%0b required 1 1",
                     err, err_cnt, tmo);
        end
        for (int i = 0; i < 300; i++) begin
            e = '{index: ATT_AW'(i), ct_addr: ATT_CTW'($urandom),
                  mask: ATT_MW'($urandom)};
            send_one(e, tmo);
            if (tmo) tmo_cnt++;
        end
        checks++;
        if (tmo_cnt !== 0 || err !== 1'b1 || err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL verr_sat err=%0b cnt=%0d tmo=%0d required 1 255",
                     err, err_cnt, tmo_cnt);
        end
        corrupt = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_sweep;
        int n;
        int bad;
        bit tmo;
        bit hit = 1'b0;
        sb_on = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.write && bus.address == ATT_AW'(2000)) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL mid_reach addr=%h required 7d0", bus.address);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.write !== 1'b0 || bus.address !== '0 || busy !== 1'b0 ||
            init_done !== 1'b0 || bus.entry_ready !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_async wr=%0b a=%h busy=%0b done=%0b err=%0b required 0",
                     bus.write, bus.address, busy, init_done, err);
        end
        @(negedge clk);
        rst = 1'b1;
        run_sweep(n, bad, tmo);
        checks++;
        if (tmo || n !== ATT_DEPTH || bad !== 0 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL mid_resweep n=%0d bad=%0d done=%0b required 4096 0 1",
                     n, bad, init_done);
        end
    endtask

    task automatic test_valid_during_init;
        att_entry_t e;
        int n;
        int bad;
        bit tmo;
        e = '{index: 12'hA5A, ct_addr: 11'h2AA, mask: 20'h55555};
        sb_on = 1'b0;
        rst = 1'b0;
        drive_entry(e);
        bus.entry_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_sweep(n, bad, tmo);
        checks++;
        if (tmo || n !== ATT_DEPTH || bad !== 0) begin
            failures++;
            $display("FAIL vinit_sweep n=%0d bad=%0d tmo=%0b required 4096 0",
                     n, bad, tmo);
        end
        checks++;
        if (bus.entry_ready !== 1'b1) begin
            failures++;
            $display("FAIL vinit_rdy got=%0b required 1", bus.entry_ready);
        end
        sb_q.push_back(e);
        sb_on = 1'b1;
        @(negedge clk);
        bus.entry_valid = 1'b0;
        checks++;
        if (bus.write !== 1'b1 || bus.address !== e.index ||
            bus.CT_address_in !== e.ct_addr || bus.Mask_in !== e.mask) begin
            failures++;
            $display("FAIL vinit_write wr=%0b a=%h required 1 %h",
                     bus.write, bus.address, e.index);
        end
        wait_ready(tmo);
        checks++;
        if (tmo || sb_q.size() !== 0) begin
            failures++;
            $display("FAIL vinit_done tmo=%0b left=%0d required 0 0", tmo, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifdef ATT_WRITER_VERIFY_EN
        test_verify_err();
`endif
        test_reset_mid_sweep();
        test_valid_during_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/att_table_writer.md
# att_table_writer

Programming-side engine for the address translation table. It clears every table entry after reset, then accepts entries from the host/config side over a valid/ready handshake and drives the table's write port. Optionally it reads each entry back and compares it against what was written. It sits between configuration logic and the table, and is the only writer of `CT_address_in`, `Mask_in` and `write`.

## Interface
- `DEPTH`, 4096: number of table entries.
- `AW`, 12: table index width; `DEPTH` = 2**`AW`.
- `CTW`, 11: CT address field width.
- `MW`, 20: mask field width.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `entry_valid`  in  1  host entry present.
- `entry_ready`  out  1  writer can accept an entry this cycle.
- `entry_index`  in  AW  table index to program.
- `entry_ct_addr`  in  CTW  CT address value.
- `entry_mask`  in  MW  mask value.
- `write`  out  1  table write strobe.
- `read`  out  1  table read strobe; verify only, otherwise 0.
- `address`  out  AW  table index.
- `CT_address_in`  out  CTW  write data, CT field.
- `Mask_in`  out  MW  write data, mask field.
- `CT_address`  in  CTW  table read data; valid 1 cycle after `read`.
- `Mask`  in  MW  table read data; valid 1 cycle after `read`.
- `init_done`  out  1  clear sweep finished; sticky until reset.
- `busy`  out  1  high in any state except IDLE.
- `err`  out  1  sticky verify mismatch flag.
- `err_cnt`  out  8  saturating mismatch count.

## Operation
- States: INIT, IDLE, WRITE, and (verify build only) VRD and VCMP.
- **Reset value of every output:** all 0, including `entry_ready`, `init_done`, `err` and `err_cnt`. The state register is forced to INIT, with the sweep counter at 0.
- **INIT:**
  - Each cycle: `write`=1, `address`=counter, both data fields 0; the counter increments.
  - After the write of index `DEPTH`-1, go to IDLE and set `init_done`=1.
  - `entry_ready`=0 throughout.
- **IDLE:**
  - `entry_ready`=1, `write`=0, `read`=0.
  - On `entry_valid` && `entry_ready`: latch index, CT address and mask, then go to WRITE.
- **WRITE:** exactly one cycle with `write`=1 and the latched values on `address`, `CT_address_in` and `Mask_in`.
  - Without verify: return to IDLE.
  - With verify: go to VRD.
- **VRD:** one cycle with `read`=1, `write`=0, `address` = latched index.
- **VCMP:**
  - Compare `CT_address` and `Mask` against the latched values.
  - On mismatch: set `err` and increment `err_cnt`, which saturates at 255.
  - Go to IDLE.
- `write` and `read` are never high in the same cycle.
- A repeated index simply overwrites the entry; no hazard tracking.

## Timing
- All outputs are registered.
- Sweep length: `write` is high for exactly `DEPTH` consecutive cycles.
  - The first sweep write is visible in the first cycle after `rst` deasserts.
  - `init_done` rises in the cycle after the last sweep write.
- Handshake latency: acceptance in cycle t gives `write`=1 in cycle t+1.
  - Without verify: `entry_ready` is back to 1 in t+2, so throughput is 1 entry per 2 cycles.
  - With verify: `read` in t+2, compare in t+3, `entry_ready` in t+4.
- `entry_valid` held high during INIT is not consumed; it is accepted in the first IDLE cycle.
- Reset asserted mid-sweep or mid-write: all outputs clear immediately (asynchronously), and the sweep restarts from index 0 after release. A partially written entry is not retried.

## Configuration
- Macro `ATT_WRITER_VERIFY_EN`.
- **Defined:** VRD and VCMP exist, and `err`/`err_cnt` are live.
- **Undefined:**
  - VRD and VCMP are not compiled.
  - `read` is tied to 0.
  - `err` and `err_cnt` are tied to 0.
  - `CT_address` and `Mask` are ignored.

## Structure
- Shared package `att_pkg`:
  - width constants `ATT_AW`=12, `ATT_CTW`=11, `ATT_MW`=20, `ATT_DEPTH`=4096;
  - state enum `att_wr_state_t`;
  - packed struct `att_entry_t` (index, ct_addr, mask).
- One natural sub-module: `att_verify_chk`. It holds the compare and saturating-counter logic and is instantiated only under `ATT_WRITER_VERIFY_EN`.

## Test plan
- **Reset then release:** `write`=1 for exactly 4096 cycles, `address` runs 0..4095 with data 0, then `init_done`=1 and `entry_ready`=1.
- **Single entry** (index 0x123, ct 0x5A5, mask 0xABCDE) accepted in cycle t: `write`=1 in t+1 with those exact values, `entry_ready`=1 in t+2 (verify off).
- **Back-to-back entries** with `entry_valid` held high: one accepted every 2 cycles, no lost or duplicated writes, `write`/`read` never both high.
- **Verify build, table model corrupts mask bit 0:** `err`=1 and `err_cnt`=1 after VCMP. After 300 more corrupted writes, `err_cnt` stays at 255.
- **`rst` pulsed low at sweep index 2000:** outputs go to 0 immediately, and the sweep restarts at index 0 and runs the full 4096 cycles.
- **`entry_valid` high from reset release:** no acceptance during INIT; accepted in the first IDLE cycle, with `write` in the next cycle.
